// File: rtl/bus_arbiter_pkg.sv
// Shared SoC bus definitions: arbiter state encoding, timeout default and the
// read value returned on a timed-out transfer.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ERR_RDATA       = 32'h0;

    // The wait counter only has to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout < 3) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and bus-side signals of the arbiter. The master modport is the
// arbiter itself; the slave modport is the environment (requesters plus bus target).
interface bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_write;
    logic [32*N_REQ-1:0] req_addr;
    logic [32*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]    ack;
    logic                err;
    logic [31:0]         rdata;
    logic [2:0]          grant_id;

    logic                W_STB;
    logic [31:0]         W_ADDR;
    logic [31:0]         W_DATA_O;
    logic                W_WRITE;
    logic [31:0]         W_DATA_I;
    logic                W_ACK;

    modport master (
        input  req, req_write, req_addr, req_wdata, W_DATA_I, W_ACK,
        output ack, err, rdata, grant_id, W_STB, W_ADDR, W_DATA_O, W_WRITE
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, W_DATA_I, W_ACK,
        input  ack, err, rdata, grant_id, W_STB, W_ADDR, W_DATA_O, W_WRITE
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner search starting one past the last grant.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last_grant,
    output logic [2:0]       winner,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        // First hit in order last_grant+1, last_grant+2, ... wins; later hits are masked by valid.
        for (int off = 1; off <= N_REQ; off++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid && req[j] && (j == (int'(last_grant) + off) % N_REQ)) begin
                    valid  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting N_REQ requesters single transfers on one bus,
// with a bounded wait for W_ACK that completes with err on expiry.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic         clk,
    input logic         W_RST,
    bus_arbiter_if.master bus
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         last_grant_q, last_grant_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               write_q, write_d;
    logic               stb_q, stb_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   ack_q, ack_d;

    logic [2:0]         pick_id;
    logic               pick_valid;
    logic [31:0]        pick_addr, pick_wdata;
    logic               pick_write;
    logic               timeout_hit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_write = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == pick_id) begin
                pick_addr  = bus.req_addr[32*j +: 32];
                pick_wdata = bus.req_wdata[32*j +: 32];
                pick_write = bus.req_write[j];
            end
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: next-state logic uses blocking assignments; only the register block uses <=.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        write_d      = write_q;
        stb_d        = stb_q;
        err_d        = 1'b0;
        ack_d        = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_id;
                    addr_d     = pick_addr;
                    wdata_d    = pick_wdata;
                    write_d    = pick_write;
                    stb_d      = 1'b1;
                    cnt_d      = '0;
                    state_d    = BUS;
                end
            end
            BUS: begin
                // A W_ACK on the expiry edge still wins, so it is tested first.
                if (bus.W_ACK || timeout_hit) begin
                    stb_d        = 1'b0;
                    write_d      = 1'b0;
                    last_grant_d = grant_id_q;
                    state_d      = DONE;
                    for (int j = 0; j < N_REQ; j++) begin
                        if (3'(j) == grant_id_q) ack_d[j] = 1'b1;
                    end
                    if (bus.W_ACK) begin
                        if (!write_q) rdata_d = bus.W_DATA_I;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 3'(N_REQ - 1);
            grant_id_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            write_q      <= 1'b0;
            stb_q        <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            write_q      <= write_d;
            stb_q        <= stb_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.grant_id = grant_id_q;
    assign bus.W_STB    = stb_q;
    assign bus.W_ADDR   = addr_q;
    assign bus.W_DATA_O = wdata_q;
    assign bus.W_WRITE  = write_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter; a transaction-level model
// predicts winners, completion timing, err and rdata.
module tb_bus_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 255;

    logic clk;
    logic W_RST;
    int   cyc = 0;

    int          checks = 0;
    int          errors = 0;
    string       step   = "reset";

    int          m_last;
    logic [31:0] m_rdata;

    bus_arbiter_if #(.N_REQ(N)) bus ();

    bus_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .W_RST (W_RST),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
        end
    endtask

    // Round-robin rule: first active requester after the last one served.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int off = 1; off <= N; off++) begin
            int idx = (m_last + off) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Called at a negedge with the FSM idle and bus.req already set. delay is the
    // number of cycles after W_STB rises at which W_ACK is presented (0 = never).
    task automatic xfer(input int delay, input logic [31:0] din, input bit drop,
                        output int gid, output int ack_cyc);
        int          w;
        logic [31:0] e_addr, e_wd;
        logic        e_wr, e_err;
        logic [N-1:0] oh;
        bit          done;
        w       = model_pick(bus.req);
        e_addr  = bus.req_addr[32*w +: 32];
        e_wd    = bus.req_wdata[32*w +: 32];
        e_wr    = bus.req_write[w];
        oh      = N'(1 << w);
        ack_cyc = -1;
        @(posedge clk); @(negedge clk);
        gid = int'(bus.grant_id);
        check("grant_id", bus.grant_id, w);
        check("stb_rise", {bus.W_STB, bus.ack}, {1'b1, 4'b0});
        check("addr", bus.W_ADDR, e_addr);
        check("write", bus.W_WRITE, e_wr);
        check("wdata", bus.W_DATA_O, e_wd);
        done = 1'b0;
        for (int c = 1; c <= TIMEOUT && !done; c++) begin
            bus.W_ACK     = (c == delay);
            bus.W_DATA_I  = (c == delay) ? din : $urandom;
            bus.req_addr  = {$urandom, $urandom, $urandom, $urandom};
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.req_write = N'($urandom);
            if (drop && c == 1) bus.req[w] = 1'b0;
            @(posedge clk); @(negedge clk);
            bus.W_ACK = 1'b0;
            if (c == delay || c == TIMEOUT) begin
                done  = 1'b1;
                e_err = (c != delay);
                if (e_err) m_rdata = 32'h0;
                else if (!e_wr) m_rdata = din;
                m_last  = w;
                ack_cyc = cyc;
                check("ack", bus.ack, oh);
                check("err", bus.err, e_err);
                check("rdata", bus.rdata, m_rdata);
                check("stb_fall", {bus.W_STB, bus.W_WRITE}, 2'b00);
            end else begin
                check("busy", {bus.W_STB, bus.ack, bus.err}, {1'b1, 4'b0, 1'b0});
                check("addr_hold", bus.W_ADDR, e_addr);
            end
        end
        bus.req[w] = 1'b0;
        bus.W_ACK  = 1'($urandom);
        @(posedge clk); @(negedge clk);
        check("idle", {bus.W_STB, bus.ack, bus.err}, 6'b0);
        bus.W_ACK = 1'b0;
    endtask

    initial begin
        int gid, ac, prev_ac;
        m_last  = N - 1;
        m_rdata = 32'h0;
        W_RST         = 1'b1;
        bus.req       = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.W_DATA_I  = '0;
        bus.W_ACK     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stb", bus.W_STB, 1'b0);
        check("ack_err", {bus.ack, bus.err}, 5'b0);
        check("rdata", bus.rdata, 32'h0);
        check("grant_id", bus.grant_id, 3'd0);
        check("bus_out", {bus.W_ADDR, bus.W_DATA_O, bus.W_WRITE}, 65'b0);
        W_RST = 1'b0;

        step = "ack_in_idle";
        bus.W_ACK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("quiet", {bus.W_STB, bus.ack, bus.err}, 6'b0);
        end
        bus.W_ACK = 1'b0;

        step = "single_read";
        bus.req = 4'b0001;
        bus.req_addr[31:0] = 32'h100;
        bus.req_write[0]   = 1'b0;
        xfer(1, 32'hCAFEF00D, 1'b0, gid, ac);
        check("rdata_val", bus.rdata, 32'hCAFEF00D);

        step = "single_write";
        bus.req = 4'b0100;
        bus.req_wdata[95:64] = 32'h12345678;
        bus.req_write[2]     = 1'b1;
        xfer(2, 32'hDEADBEEF, 1'b0, gid, ac);
        check("rdata_kept", bus.rdata, 32'hCAFEF00D);

        step = "timeout";
        bus.req = 4'b0010;
        bus.req_write[1] = 1'b0;
        xfer(0, 32'h0, 1'b0, gid, ac);

        step = "ack_at_timeout_edge";
        bus.req = 4'b0001;
        bus.req_write[0] = 1'b0;
        xfer(TIMEOUT, 32'h5A5A0001, 1'b0, gid, ac);

        step = "drop_in_bus";
        bus.req = 4'b0001;
        xfer(3, 32'h0BADCAFE, 1'b1, gid, ac);

        step = "reset_mid_bus";
        bus.req = 4'b0010;
        @(posedge clk); @(negedge clk);
        check("stb_rise", bus.W_STB, 1'b1);
        W_RST     = 1'b1;
        bus.W_ACK = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abandon", {bus.W_STB, bus.ack, bus.err}, 6'b0);
        check("grant_rst", bus.grant_id, 3'd0);
        check("rdata_rst", bus.rdata, 32'h0);
        W_RST     = 1'b0;
        bus.W_ACK = 1'b0;
        bus.req   = 4'b0000;
        m_last    = N - 1;
        m_rdata   = 32'h0;
        @(posedge clk); @(negedge clk);
        check("no_ack", {bus.W_STB, bus.ack}, 5'b0);

        step = "fairness";
        prev_ac = 0;
        for (int i = 0; i < 8; i++) begin
            bus.req = 4'b1111;
            xfer(1, $urandom, 1'b0, gid, ac);
            check("rotation", gid, i % N);
            if (i > 0) check("ack_spacing", ac - prev_ac, 3);
            prev_ac = ac;
        end

        step = "random";
        for (int i = 0; i < 24; i++) begin
            bus.req       = N'($urandom_range(1, 15));
            bus.req_addr  = {$urandom, $urandom, $urandom, $urandom};
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
            bus.req_write = N'($urandom);
            xfer($urandom_range(1, 6), $urandom, 1'($urandom), gid, ac);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  N_REQ, 4, number of requesters (2..8)
  TIMEOUT, 255, maximum bus cycles waited for W_ACK before an error completion
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock for all logic
  W_RST  in  1  reset, synchronous, active-high
  req  in  N_REQ  per-requester access request, held until its ack
  req_write  in  N_REQ  per-requester 1=write, 0=read
  req_addr  in  32*N_REQ  per-requester address, slice i = bits 32*i+31..32*i
  req_wdata  in  32*N_REQ  per-requester write data, same slicing
  ack  out  N_REQ  one-cycle completion pulse to the granted requester
  err  out  1  one-cycle pulse coincident with ack when completion was by timeout
  rdata  out  32  read data of the last completed transfer
  grant_id  out  3  index of the current or last granted requester
  W_STB  out  1  bus cycle valid
  W_ADDR  out  32  bus address
  W_DATA_O  out  32  bus write data
  W_WRITE  out  1  bus write strobe
  W_DATA_I  in  32  bus read data
  W_ACK  in  1  bus completion
REQ-003 The clock SHALL be clk; reset SHALL be W_RST, synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, BUS, DONE.
REQ-005 IDLE: when req is nonzero at a rising edge, the FSM SHALL select the winner round-robin, searching from (last_grant+1) mod N_REQ upward with wrap. It SHALL register grant_id, W_ADDR, W_DATA_O and W_WRITE from the winner's slices, set W_STB=1, clear the timeout counter, and go to BUS.
REQ-006 BUS: W_ADDR, W_DATA_O and W_WRITE SHALL stay constant. Changes on any req_* input SHALL be ignored, and a dropped req SHALL NOT abort the transfer.
REQ-007 BUS, W_ACK=1 at an edge: the FSM SHALL set W_STB=0, W_WRITE=0, rdata<=W_DATA_I (reads only; rdata is unchanged on writes), ack[grant_id]<=1, last_grant<=grant_id, and go to DONE.
REQ-008 BUS, no W_ACK: the counter SHALL increment. When it equals TIMEOUT-1 at an edge, the FSM SHALL act as REQ-007 but with err<=1 and rdata<=32'h0.
REQ-009 W_ACK arriving on the same edge as the timeout SHALL be treated as a normal completion with err=0.
REQ-010 DONE: the FSM SHALL clear ack and err and go to IDLE unconditionally, with no arbitration in DONE. Requesters drop req during the ack cycle.
REQ-011 Minimum latency: req sampled at edge k gives W_STB high after edge k. If W_ACK=1 at edge k+1, ack is high for the cycle after edge k+1 and the FSM is in IDLE after edge k+2. Back-to-back throughput SHALL be one transfer per 3 cycles.
REQ-012 ack SHALL be one-hot or zero at all times, and SHALL be high for exactly one cycle per granted transfer.
REQ-013 W_ACK in IDLE or DONE SHALL be ignored.
REQ-014 A single continuous requester SHALL be re-granted each round. With all requesters active, grants SHALL rotate 0,1,2,...,N_REQ-1,0.

Reset
REQ-015 W_RST SHALL set: state=IDLE; W_STB=0, W_WRITE=0, W_ADDR=0, W_DATA_O=0; ack=0, err=0, rdata=0, grant_id=0; counter=0; last_grant=N_REQ-1, so requester 0 has first priority.
REQ-016 W_RST during BUS SHALL abandon the transfer: W_STB=0 after the edge and no ack is issued.
REQ-017 W_RST SHALL take priority over every other event at the same edge.

Structure
REQ-018 State encodings (IDLE/BUS/DONE), the TIMEOUT default and the error read value 32'h0 SHALL live in the shared SoC bus definitions file.
REQ-019 The round-robin winner selection (req, last_grant -> winner index, valid) SHALL be a combinational sub-module rr_pick. Everything else SHALL be in bus_arbiter.

Verification
REQ-020 Bench scenarios:
- Single read: req=0001, addr0=0x100, W_ACK one cycle after W_STB with W_DATA_I=0xCAFEF00D -> W_ADDR=0x100, W_WRITE=0, ack=0001 for one cycle, rdata=0xCAFEF00D.
- Single write: req=0100, wdata2=0x12345678 -> W_WRITE=1, W_DATA_O=0x12345678, ack=0100, rdata unchanged.
- Fairness: req=1111 held, each requester dropping req after its ack and re-raising it, 8 transfers -> grant_id sequence 0,1,2,3,0,1,2,3, ack spacing 3 cycles.
- Timeout: req=0010, W_ACK never asserted, TIMEOUT=255 -> ack=0010 with err=1 exactly 255 cycles after W_STB rose, rdata=0, W_STB=0.
- Reset mid-transfer: W_RST pulsed in BUS -> W_STB=0 next cycle, no ack pulse, next grant goes to requester 0.
- Request dropped in BUS: req0 deasserted while W_STB=1 -> transfer completes, ack=0001 still pulsed.
